cacheline_adaptor: RTL and testbench

Bridges the 256-bit line-granular physical-memory port of the cache datapath to a 64-bit burst memory bus. Accepts one line read or line write request from the cache, performs a 4-beat burst on the memory side, and returns a single-cycle response. It sits directly downstream of the cache datapath and its controller; the cache's `pmem_*` signals connect here.

---
 rtl/cacheline_adaptor_pkg.sv | 15 +
 rtl/cacheline_adaptor.sv | 123 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and widths for the cache-line to burst-bus adaptor.
package cacheline_adaptor_pkg;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int BEATS   = LINE_W / BURST_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } adaptor_state_t;

endpackage : cacheline_adaptor_pkg

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit line request from the cache to a 4-beat 64-bit memory burst.
// Every output comes straight from a flop, so nothing on the cache side reaches
// the memory side combinationally.
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   adaptor_state_t     r_state;
   logic [1:0]         r_beat;
   logic [LINE_W-1:0]  r_buf;
   logic [BURST_W-1:0] r_burst_o;
   logic [31:0]        r_address_o;
   logic               r_read_o;
   logic               r_write_o;
   logic               r_resp_o;
   logic [1:0]         w_next_beat;

   // Next beat index; wraps to zero after the last beat, which is harmless
   // because the FSM leaves READ/WRITE on that beat.
   assign w_next_beat = r_beat + 2'd1;

   // Transaction FSM: beat counter, line buffer and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_beat      <= 2'd0;
         r_buf       <= '0;
         r_burst_o   <= '0;
         r_address_o <= 32'd0;
         r_read_o    <= 1'b0;
         r_write_o   <= 1'b0;
         r_resp_o    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_resp_o <= 1'b0;
               r_beat   <= 2'd0;
               if (write_i) begin
                  // Write wins when both requests are present.
                  r_buf       <= line_i;
                  r_burst_o   <= line_i[BURST_W-1:0];
                  r_address_o <= {address_i[31:5], 5'b0_0000};
                  r_write_o   <= 1'b1;
                  r_state     <= WRITE;
               end else if (read_i) begin
                  r_address_o <= {address_i[31:5], 5'b0_0000};
                  r_read_o    <= 1'b1;
                  r_state     <= READ;
               end else begin
                  r_state <= IDLE;
               end
            end
            READ: begin
               if (resp_i) begin
                  r_buf[r_beat*BURST_W +: BURST_W] <= burst_i;
                  r_beat <= w_next_beat;
                  if (r_beat == 2'd3) begin
                     r_read_o <= 1'b0;
                     r_resp_o <= 1'b1;
                     r_state  <= DONE;
                  end else begin
                     r_state <= READ;
                  end
               end else begin
                  r_state <= READ;
               end
            end
            WRITE: begin
               if (resp_i) begin
                  // Present the following beat so it is ready on the next strobe.
                  r_burst_o <= r_buf[w_next_beat*BURST_W +: BURST_W];
                  r_beat    <= w_next_beat;
                  if (r_beat == 2'd3) begin
                     r_write_o <= 1'b0;
                     r_resp_o  <= 1'b1;
                     r_state   <= DONE;
                  end else begin
                     r_state <= WRITE;
                  end
               end else begin
                  r_state <= WRITE;
               end
            end
            DONE: begin
               // Requests still held here are deliberately ignored.
               r_resp_o <= 1'b0;
               r_beat   <= 2'd0;
               r_state  <= IDLE;
            end
            default: begin
               r_resp_o  <= 1'b0;
               r_read_o  <= 1'b0;
               r_write_o <= 1'b0;
               r_beat    <= 2'd0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign line_o    = r_buf;
   assign burst_o   = r_burst_o;
   assign address_o = r_address_o;
   assign read_o    = r_read_o;
   assign write_o   = r_write_o;
   assign resp_o    = r_resp_o;

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor.
module tb_cacheline_adaptor;

   logic         clk;
   logic         rst_n;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic [31:0]  address_i;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;

   int n_tests = 0;
   int n_fail  = 0;
   int resp_cnt = 0;
   int read_cnt = 0;

   cacheline_adaptor dut (
      .clk(clk), .rst_n(rst_n),
      .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle; tallies response pulses and read cycles.
   task automatic tick();
      @(posedge clk);
      #1;
      if (resp_o === 1'b1) resp_cnt++;
      if (read_o === 1'b1) read_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      line_i = '0; burst_i = '0; address_i = 32'd0;
      tick(); tick();
      n_tests++;
      if ({read_o, write_o, resp_o} !== 3'b000) begin
         $display("FAIL reset_ctrl got %b want 000", {read_o, write_o, resp_o}); n_fail++;
      end
      n_tests++;
      if (line_o !== 256'd0 || burst_o !== 64'd0 || address_o !== 32'd0) begin
         $display("FAIL reset_data line=%h burst=%h addr=%h want zeros", line_o, burst_o, address_o); n_fail++;
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_read_basic();
      logic [63:0] d [4];
      d[0] = 64'h1111_1111_1111_1111; d[1] = 64'h2222_2222_2222_2222;
      d[2] = 64'h3333_3333_3333_3333; d[3] = 64'h4444_4444_4444_4444;
      address_i = 32'h0000_1234; read_i = 1'b1;
      tick();
      n_tests++;
      if (read_o !== 1'b1 || address_o !== 32'h0000_1220) begin
         $display("FAIL rd_start read_o=%b addr=%h want 1 00001220", read_o, address_o); n_fail++;
      end
      for (int i = 0; i < 4; i++) begin
         resp_i = 1'b1; burst_i = d[i];
         tick();
         n_tests++;
         if (resp_o !== (i == 3)) begin
            $display("FAIL rd_resp_timing beat=%0d got %b want %b", i, resp_o, (i == 3)); n_fail++;
         end
      end
      resp_i = 1'b0; read_i = 1'b0; burst_i = '0;
      n_tests++;
      if (line_o !== {d[3], d[2], d[1], d[0]} || read_o !== 1'b0) begin
         $display("FAIL rd_line got %h read_o=%b", line_o, read_o); n_fail++;
      end
      tick();
      n_tests++;
      if (resp_o !== 1'b0 || address_o !== 32'h0000_1220) begin
         $display("FAIL rd_done resp=%b addr=%h want 0 00001220", resp_o, address_o); n_fail++;
      end
      tick();
   endtask

   task automatic test_write();
      logic [63:0] d [4];
      d[0] = 64'hA0A0_0000_0000_00D0; d[1] = 64'hB1B1_0000_0000_00D1;
      d[2] = 64'hC2C2_0000_0000_00D2; d[3] = 64'hE3E3_0000_0000_00D3;
      line_i = {d[3], d[2], d[1], d[0]};
      address_i = 32'h8000_0047; write_i = 1'b1;
      tick();
      n_tests++;
      if (write_o !== 1'b1 || burst_o !== d[0] || address_o !== 32'h8000_0040) begin
         $display("FAIL wr_start write_o=%b burst=%h addr=%h", write_o, burst_o, address_o); n_fail++;
      end
      // Stall before the first strobe: beat 0 must be held.
      resp_i = 1'b0;
      tick();
      n_tests++;
      if (burst_o !== d[0] || write_o !== 1'b1) begin
         $display("FAIL wr_stall burst=%h want %h", burst_o, d[0]); n_fail++;
      end
      for (int i = 0; i < 4; i++) begin
         resp_i = 1'b1;
         tick();
         if (i < 3) begin
            n_tests++;
            if (burst_o !== d[i+1] || write_o !== 1'b1 || resp_o !== 1'b0) begin
               $display("FAIL wr_beat%0d burst=%h want %h write_o=%b resp=%b", i, burst_o, d[i+1], write_o, resp_o); n_fail++;
            end
         end else begin
            n_tests++;
            if (write_o !== 1'b0 || resp_o !== 1'b1) begin
               $display("FAIL wr_end write_o=%b resp=%b want 0 1", write_o, resp_o); n_fail++;
            end
         end
      end
      resp_i = 1'b0; write_i = 1'b0;
      tick();
      n_tests++;
      if (resp_o !== 1'b0) begin
         $display("FAIL wr_pulse resp=%b want 0", resp_o); n_fail++;
      end
      tick();
   endtask

   task automatic test_stall_read();
      logic        pat [7];
      logic [63:0] d [4];
      int          k;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      d[0] = 64'h0123_4567_89AB_CDEF; d[1] = 64'hFEDC_BA98_7654_3210;
      d[2] = 64'h5555_AAAA_5555_AAAA; d[3] = 64'h0F0F_F0F0_0F0F_F0F0;
      address_i = 32'h0000_00FF; read_i = 1'b1;
      tick();
      k = 0;
      for (int i = 0; i < 7; i++) begin
         resp_i = pat[i];
         burst_i = pat[i] ? d[k] : 64'hDEAD_BEEF_DEAD_BEEF;
         if (pat[i]) k++;
         tick();
         n_tests++;
         if (resp_o !== (i == 6)) begin
            $display("FAIL stall_resp cyc=%0d got %b want %b", i, resp_o, (i == 6)); n_fail++;
         end
      end
      resp_i = 1'b0; read_i = 1'b0;
      n_tests++;
      if (line_o !== {d[3], d[2], d[1], d[0]} || address_o !== 32'h0000_00E0) begin
         $display("FAIL stall_line got %h addr=%h", line_o, address_o); n_fail++;
      end
      tick(); tick();
   endtask

   task automatic test_priority();
      line_i = {64'h4, 64'h3, 64'h2, 64'h1};
      address_i = 32'h0000_0400; read_i = 1'b1; write_i = 1'b1;
      read_cnt = 0;
      tick();
      n_tests++;
      if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== 64'h1) begin
         $display("FAIL prio_start write_o=%b read_o=%b burst=%h", write_o, read_o, burst_o); n_fail++;
      end
      resp_i = 1'b1;
      tick(); tick(); tick(); tick();
      n_tests++;
      if (resp_o !== 1'b1) begin
         $display("FAIL prio_resp got %b want 1", resp_o); n_fail++;
      end
      resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
      tick(); tick();
      n_tests++;
      if (read_cnt !== 0) begin
         $display("FAIL prio_read_o read cycles=%0d want 0", read_cnt); n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      address_i = 32'h0000_2000; read_i = 1'b1;
      tick();
      resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
      tick(); tick();
      resp_i = 1'b0;
      resp_cnt = 0;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (read_o !== 1'b0 || line_o !== 256'd0) begin
         $display("FAIL midrst read_o=%b line=%h want 0 0", read_o, line_o); n_fail++;
      end
      read_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      // Fresh read must fill from beat 0.
      read_i = 1'b1; address_i = 32'h0000_3000;
      tick();
      for (int i = 0; i < 4; i++) begin
         resp_i = 1'b1; burst_i = 64'h0 + 64'(i + 5);
         tick();
      end
      resp_i = 1'b0; read_i = 1'b0;
      n_tests++;
      if (line_o !== {64'd8, 64'd7, 64'd6, 64'd5} || resp_cnt != 1) begin
         $display("FAIL midrst_reread line=%h resp_pulses=%0d want 1", line_o, resp_cnt); n_fail++;
      end
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      resp_cnt = 0; read_cnt = 0;
      address_i = 32'h0000_0040; read_i = 1'b1;
      tick();
      resp_i = 1'b1;
      tick(); tick(); tick(); tick();
      resp_i = 1'b0;
      tick();                     // DONE edge, read_i still high
      read_i = 1'b0;
      tick();
      n_tests++;
      if (read_o !== 1'b0) begin
         $display("FAIL b2b_retrigger read_o=%b want 0", read_o); n_fail++;
      end
      tick();
      read_i = 1'b1;
      tick();
      resp_i = 1'b1;
      tick(); tick(); tick(); tick();
      resp_i = 1'b0; read_i = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      n_tests++;
      if (resp_cnt != 2 || read_cnt != 8) begin
         $display("FAIL b2b_count resp_pulses=%0d read_cycles=%0d want 2 8", resp_cnt, read_cnt); n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write();
      test_stall_read();
      test_priority();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_cacheline_adaptor
